// File: rtl/ace_iq_pkg.sv
// Shared types and helpers for the ace issue queue: entry status flags,
// dispatch ready-bit offsets, default geometry and the hardwired-ready tag.
package ace_iq_pkg;

  localparam int DEF_ENTRIES = 16;
  localparam int DEF_DISP_W  = 4;
  localparam int DEF_ISSUE_W = 2;
  localparam int DEF_WAKE_W  = 6;
  localparam int DEF_PREG_W  = 7;
  localparam int DEF_ROB_W   = 6;
  localparam int DEF_PAY_W   = 64;

  // Physical register 0 is architecturally always ready.
  localparam int TAG_ZERO = 0;

  // Bit offsets within each slot's disp_src_rdy pair.
  localparam int RDY_SRC1 = 0;
  localparam int RDY_SRC2 = 1;

  typedef struct packed {
    logic valid;
    logic src1_rdy;
    logic src2_rdy;
  } iq_flags_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ace_age_select.sv
// Oldest-first picker: grants the requester that no other requester is older
// than, using age[j][i]=1 meaning entry j is older than entry i.
module ace_age_select #(
  parameter int ENTRIES = 16
) (
  input  logic [ENTRIES-1:0]              i_req,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] i_age,
  output logic [ENTRIES-1:0]              o_grant
);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_grant[i] = i_req[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (i_req[j] && i_age[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ace_issue_queue.sv
// Out-of-order issue queue: multi-slot dispatch, tag wakeup, age-matrix
// oldest-first select across ISSUE_W ports with valid/ready back-pressure.
module ace_issue_queue
  import ace_iq_pkg::*;
#(
  parameter  int ENTRIES = DEF_ENTRIES,
  parameter  int DISP_W  = DEF_DISP_W,
  parameter  int ISSUE_W = DEF_ISSUE_W,
  parameter  int WAKE_W  = DEF_WAKE_W,
  parameter  int PREG_W  = DEF_PREG_W,
  parameter  int ROB_W   = DEF_ROB_W,
  parameter  int PAY_W   = DEF_PAY_W,
  localparam int OCC_W   = clog2(ENTRIES) + 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [DISP_W-1:0]                disp_valid,
  input  logic [DISP_W-1:0][PREG_W-1:0]    disp_src1_tag,
  input  logic [DISP_W-1:0][PREG_W-1:0]    disp_src2_tag,
  input  logic [DISP_W-1:0][1:0]           disp_src_rdy,
  input  logic [DISP_W-1:0][ROB_W-1:0]     disp_rob_id,
  input  logic [DISP_W-1:0][PAY_W-1:0]     disp_payload,
  output logic                             disp_ready,
  input  logic [WAKE_W-1:0]                wake_valid,
  input  logic [WAKE_W-1:0][PREG_W-1:0]    wake_tag,
  output logic [ISSUE_W-1:0]               iss_valid,
  input  logic [ISSUE_W-1:0]               iss_ready,
  output logic [ISSUE_W-1:0][PREG_W-1:0]   iss_src1_tag,
  output logic [ISSUE_W-1:0][PREG_W-1:0]   iss_src2_tag,
  output logic [ISSUE_W-1:0][ROB_W-1:0]    iss_rob_id,
  output logic [ISSUE_W-1:0][PAY_W-1:0]    iss_payload,
  output logic [OCC_W-1:0]                 occupancy
);

  iq_flags_t [ENTRIES-1:0]              r_flg;
  logic [ENTRIES-1:0][PREG_W-1:0]       r_tag1, r_tag2;
  logic [ENTRIES-1:0][ROB_W-1:0]        r_rob;
  logic [ENTRIES-1:0][PAY_W-1:0]        r_pay;
  logic [ENTRIES-1:0][ENTRIES-1:0]      r_age;
  logic [OCC_W-1:0]                     r_occ;

  logic [ENTRIES-1:0]                   w_vld, w_req, w_wk1, w_wk2, w_fire, w_free_m, w_alloc_any;
  logic [DISP_W-1:0]                    w_dacc, w_dwk1, w_dwk2, w_drdy1, w_drdy2;
  logic [DISP_W-1:0][ENTRIES-1:0]       w_alloc_oh;
  logic [ENTRIES-1:0][ENTRIES-1:0]      w_age_nxt;
  logic [ISSUE_W-1:0][ENTRIES-1:0]      w_cand, w_gnt;
  logic [OCC_W-1:0]                     w_nalloc, w_nfire;

  // Same-cycle issue frees are deliberately not counted here.
  assign disp_ready = (r_occ <= OCC_W'(ENTRIES - DISP_W));
  assign occupancy  = r_occ;
  assign w_dacc     = disp_valid & {DISP_W{disp_ready && !flush}};

  always_comb begin
    w_vld = '0;
    w_req = '0;
    w_wk1 = '0;
    w_wk2 = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      w_vld[e] = r_flg[e].valid;
      w_req[e] = r_flg[e].valid && r_flg[e].src1_rdy && r_flg[e].src2_rdy;
      for (int w = 0; w < WAKE_W; w++) begin
        if (wake_valid[w] && (wake_tag[w] == r_tag1[e])) w_wk1[e] = 1'b1;
        if (wake_valid[w] && (wake_tag[w] == r_tag2[e])) w_wk2[e] = 1'b1;
      end
    end
  end

  // Dispatching sources also snoop this cycle's wakeups so none is lost.
  always_comb begin
    w_dwk1 = '0;
    w_dwk2 = '0;
    for (int k = 0; k < DISP_W; k++) begin
      for (int w = 0; w < WAKE_W; w++) begin
        if (wake_valid[w] && (wake_tag[w] == disp_src1_tag[k])) w_dwk1[k] = 1'b1;
        if (wake_valid[w] && (wake_tag[w] == disp_src2_tag[k])) w_dwk2[k] = 1'b1;
      end
      w_drdy1[k] = disp_src_rdy[k][RDY_SRC1] || w_dwk1[k] ||
                   (disp_src1_tag[k] == PREG_W'(TAG_ZERO));
      w_drdy2[k] = disp_src_rdy[k][RDY_SRC2] || w_dwk2[k] ||
                   (disp_src2_tag[k] == PREG_W'(TAG_ZERO));
    end
  end

  always_comb begin
    w_free_m    = ~w_vld;
    w_alloc_oh  = '0;
    w_alloc_any = '0;
    w_nalloc    = '0;
    for (int k = 0; k < DISP_W; k++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_dacc[k] && !(|w_alloc_oh[k]) && w_free_m[e]) begin
          w_alloc_oh[k][e] = 1'b1;
          w_free_m[e]      = 1'b0;
        end
      end
      w_alloc_any = w_alloc_any | w_alloc_oh[k];
      if (|w_alloc_oh[k]) w_nalloc = w_nalloc + OCC_W'(1);
    end
  end

  // New entry: younger than every resident entry and every earlier slot.
  always_comb begin
    w_age_nxt = r_age;
    for (int e = 0; e < ENTRIES; e++) begin
      if (w_alloc_any[e]) w_age_nxt[e] = '0;
    end
    for (int k = 0; k < DISP_W; k++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_alloc_oh[k][e]) begin
          for (int i = 0; i < ENTRIES; i++) begin
            if (w_vld[i]) w_age_nxt[i][e] = 1'b1;
            for (int j = 0; j < k; j++) begin
              if (w_alloc_oh[j][i]) w_age_nxt[i][e] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_cand[0] = w_req;

  for (genvar p = 0; p < ISSUE_W; p++) begin : g_sel
    ace_age_select #(.ENTRIES(ENTRIES)) u_sel (
      .i_req   (w_cand[p]),
      .i_age   (r_age),
      .o_grant (w_gnt[p])
    );
    assign iss_valid[p] = (|w_gnt[p]) && !flush;
    if (p + 1 < ISSUE_W) begin : g_nxt
      assign w_cand[p+1] = w_cand[p] & ~w_gnt[p];
    end
  end

  always_comb begin
    iss_src1_tag = '0;
    iss_src2_tag = '0;
    iss_rob_id   = '0;
    iss_payload  = '0;
    w_fire       = '0;
    w_nfire      = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_gnt[p][e]) begin
          iss_src1_tag[p] = iss_src1_tag[p] | r_tag1[e];
          iss_src2_tag[p] = iss_src2_tag[p] | r_tag2[e];
          iss_rob_id[p]   = iss_rob_id[p]   | r_rob[e];
          iss_payload[p]  = iss_payload[p]  | r_pay[e];
          if (iss_valid[p] && iss_ready[p]) w_fire[e] = 1'b1;
        end
      end
      if (iss_valid[p] && iss_ready[p]) w_nfire = w_nfire + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flg  <= '0;
      r_age  <= '0;
      r_occ  <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_rob  <= '0;
      r_pay  <= '0;
    end else if (flush) begin
      r_flg <= '0;
      r_age <= '0;
      r_occ <= '0;
    end else begin
      r_age <= w_age_nxt;
      r_occ <= r_occ + w_nalloc - w_nfire;
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_fire[e]) begin
          r_flg[e].valid <= 1'b0;
        end else if (r_flg[e].valid) begin
          if (w_wk1[e]) r_flg[e].src1_rdy <= 1'b1;
          if (w_wk2[e]) r_flg[e].src2_rdy <= 1'b1;
        end
        for (int k = 0; k < DISP_W; k++) begin
          if (w_alloc_oh[k][e]) begin
            r_flg[e]  <= '{valid: 1'b1, src1_rdy: w_drdy1[k], src2_rdy: w_drdy2[k]};
            r_tag1[e] <= disp_src1_tag[k];
            r_tag2[e] <= disp_src2_tag[k];
            r_rob[e]  <= disp_rob_id[k];
            r_pay[e]  <= disp_payload[k];
          end
        end
      end
    end
  end

  a_disp_proto: assert property (@(posedge clk) disable iff (!reset_n)
    (flush || disp_ready || !(|disp_valid)));

endmodule

// File: tb/tb_ace_issue_queue.sv
// Scoreboard bench for ace_issue_queue: dispatch pushes expected issues, a
// negedge monitor pops and compares on every accepted issue handshake.
module tb_ace_issue_queue;

  localparam int ENTRIES = 16;
  localparam int DISP_W  = 4;
  localparam int ISSUE_W = 2;
  localparam int WAKE_W  = 6;
  localparam int PREG_W  = 7;
  localparam int ROB_W   = 6;
  localparam int PAY_W   = 64;
  localparam int OCC_W   = 5;

  logic                            clk = 1'b0;
  logic                            reset_n = 1'b0;
  logic                            flush = 1'b0;
  logic [DISP_W-1:0]               disp_valid;
  logic [DISP_W-1:0][PREG_W-1:0]   disp_src1_tag, disp_src2_tag;
  logic [DISP_W-1:0][1:0]          disp_src_rdy;
  logic [DISP_W-1:0][ROB_W-1:0]    disp_rob_id;
  logic [DISP_W-1:0][PAY_W-1:0]    disp_payload;
  logic                            disp_ready;
  logic [WAKE_W-1:0]               wake_valid;
  logic [WAKE_W-1:0][PREG_W-1:0]   wake_tag;
  logic [ISSUE_W-1:0]              iss_valid, iss_ready;
  logic [ISSUE_W-1:0][PREG_W-1:0]  iss_src1_tag, iss_src2_tag;
  logic [ISSUE_W-1:0][ROB_W-1:0]   iss_rob_id;
  logic [ISSUE_W-1:0][PAY_W-1:0]   iss_payload;
  logic [OCC_W-1:0]                occupancy;

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [PAY_W-1:0] pay;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ace_issue_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_src1_tag (disp_src1_tag),
    .disp_src2_tag (disp_src2_tag),
    .disp_src_rdy  (disp_src_rdy),
    .disp_rob_id   (disp_rob_id),
    .disp_payload  (disp_payload),
    .disp_ready    (disp_ready),
    .wake_valid    (wake_valid),
    .wake_tag      (wake_tag),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_src1_tag  (iss_src1_tag),
    .iss_src2_tag  (iss_src2_tag),
    .iss_rob_id    (iss_rob_id),
    .iss_payload   (iss_payload),
    .occupancy     (occupancy)
  );

  function automatic logic [PAY_W-1:0] pay_of(input int rob);
    return 64'hC0DE_0000_0000_0000 | 64'(rob * 257);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    disp_valid = '0;
  endtask

  // rdy bit0 = src1 ready, bit1 = src2 ready.
  task automatic put(input int k, input int rob, input int t1, input int t2,
                     input logic [1:0] rdy, input bit expect_issue);
    exp_t e;
    disp_valid[k]    = 1'b1;
    disp_rob_id[k]   = ROB_W'(rob);
    disp_src1_tag[k] = PREG_W'(t1);
    disp_src2_tag[k] = PREG_W'(t2);
    disp_src_rdy[k]  = rdy;
    disp_payload[k]  = pay_of(rob);
    if (expect_issue) begin
      e.rob = ROB_W'(rob);
      e.pay = pay_of(rob);
      exp_q.push_back(e);
    end
  endtask

  task automatic wake(input int w, input int t);
    wake_valid[w] = 1'b1;
    wake_tag[w]   = PREG_W'(t);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (occupancy != '0 && n < 30) begin
      cyc();
      n++;
    end
    #1 chk(name, 64'(occupancy), 64'd0);
  endtask

  // Monitor: every accepted handshake must match the next expected issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        for (int p = 0; p < ISSUE_W; p++) begin
          if (iss_valid[p] && iss_ready[p]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_issue: port %0d rob %0d, expected no issue", p, iss_rob_id[p]);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("issue_rob_p%0d", p), 64'(iss_rob_id[p]), 64'(e.rob));
              chk($sformatf("issue_pay_p%0d", p), iss_payload[p], e.pay);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at 100000, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    disp_valid = '0; disp_src1_tag = '0; disp_src2_tag = '0; disp_src_rdy = '0;
    disp_rob_id = '0; disp_payload = '0; wake_valid = '0; wake_tag = '0;
    iss_ready = '1;
    cyc(); cyc();
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_rob", 64'(iss_rob_id), 64'd0);
    chk("rst_pay", iss_payload[0], 64'd0);
    reset_n = 1'b1;

    // Two ready instructions issue together the next cycle.
    cyc(); put(0, 5, 1, 2, 2'b11, 1); put(1, 6, 3, 4, 2'b11, 1);
    cyc(); clr();
    #1 chk("t1_iss_valid", 64'(iss_valid), 64'h3);
    chk("t1_occ", 64'(occupancy), 64'd2);
    chk("t1_p0_rob", 64'(iss_rob_id[0]), 64'd5);
    chk("t1_p1_rob", 64'(iss_rob_id[1]), 64'd6);
    cyc(); #1 chk("t1_occ_drained", 64'(occupancy), 64'd0);

    // Wakeup two cycles after dispatch; no early issue.
    cyc(); put(0, 3, 12, 13, 2'b10, 1);
    cyc(); clr(); #1 chk("t2_not_ready_a", 64'(iss_valid), 64'd0);
    cyc(); wake(0, 12); #1 chk("t2_not_ready_b", 64'(iss_valid), 64'd0);
    cyc(); wake_valid = '0; #1 chk("t2_woken", 64'(iss_valid), 64'd1);
    chk("t2_rob", 64'(iss_rob_id[0]), 64'd3);
    cyc(); #1 chk("t2_occ", 64'(occupancy), 64'd0);

    // Wakeup in the dispatch cycle is captured.
    cyc(); put(0, 7, 20, 21, 2'b10, 1); wake(5, 20);
    cyc(); clr(); wake_valid = '0;
    #1 chk("t3_capture", 64'(iss_valid), 64'd1);
    chk("t3_rob", 64'(iss_rob_id[0]), 64'd7);
    cyc(); #1 chk("t3_occ", 64'(occupancy), 64'd0);

    // Fill to 13 entries with back-pressure on both ports.
    cyc(); iss_ready = '0;
    for (int k = 0; k < 4; k++) put(k, 10 + k, 1, 2, 2'b11, 1);
    cyc(); for (int k = 0; k < 4; k++) put(k, 14 + k, 1, 2, 2'b11, 1);
    cyc(); for (int k = 0; k < 4; k++) put(k, 18 + k, 1, 2, 2'b11, 1);
    cyc(); clr(); #1 chk("t4_ready_at_12", 64'(disp_ready), 64'd1);
    put(0, 22, 1, 2, 2'b11, 1);
    cyc(); clr();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      #1 chk("t4_disp_ready_low", 64'(disp_ready), 64'd0);
      chk("t4_hold_occ", 64'(occupancy), 64'd13);
      chk("t4_hold_valid", 64'(iss_valid), 64'h3);
      chk("t4_hold_p0_rob", 64'(iss_rob_id[0]), 64'd10);
      chk("t4_hold_p1_rob", 64'(iss_rob_id[1]), 64'd11);
    end
    cyc(); iss_ready = '1;
    wait_empty("t4_drain");

    // Age order: wake sources in reverse order in one cycle; src2 is tag 0.
    cyc(); for (int k = 0; k < 4; k++) put(k, 1 + k, 30 + k, 0, 2'b00, 1);
    cyc(); clr(); #1 chk("t5_blocked_a", 64'(iss_valid), 64'd0);
    cyc(); for (int w = 0; w < 4; w++) wake(w, 33 - w);
    #1 chk("t5_blocked_b", 64'(iss_valid), 64'd0);
    cyc(); wake_valid = '0;
    #1 chk("t5_valid", 64'(iss_valid), 64'h3);
    chk("t5_p0_rob1", 64'(iss_rob_id[0]), 64'd1);
    chk("t5_p1_rob2", 64'(iss_rob_id[1]), 64'd2);
    cyc(); #1 chk("t5_p0_rob3", 64'(iss_rob_id[0]), 64'd3);
    chk("t5_p1_rob4", 64'(iss_rob_id[1]), 64'd4);
    cyc(); #1 chk("t5_occ", 64'(occupancy), 64'd0);

    // Flush with 8 resident entries and a same-cycle dispatch.
    cyc(); iss_ready = '0;
    for (int k = 0; k < 4; k++) put(k, 40 + k, 1, 2, 2'b11, 0);
    cyc(); for (int k = 0; k < 4; k++) put(k, 44 + k, 1, 2, 2'b11, 0);
    cyc(); clr();
    #1 chk("t6_occ8", 64'(occupancy), 64'd8);
    chk("t6_pre_valid", 64'(iss_valid), 64'h3);
    cyc(); flush = 1'b1; iss_ready = '1;
    for (int k = 0; k < 4; k++) put(k, 48 + k, 1, 2, 2'b11, 0);
    #1 chk("t6_flush_gate", 64'(iss_valid), 64'd0);
    cyc(); flush = 1'b0; clr();
    #1 chk("t6_occ0", 64'(occupancy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      cyc(); #1 chk("t6_no_issue", 64'(iss_valid), 64'd0);
    end

    // Asynchronous reset mid-cycle with ready entries held.
    cyc(); iss_ready = '0;
    put(0, 60, 1, 2, 2'b11, 0); put(1, 61, 3, 4, 2'b11, 0);
    cyc(); clr(); #1 chk("t7_pre_valid", 64'(iss_valid), 64'h3);
    #2 reset_n = 1'b0;
    #1 chk("t7_rst_valid", 64'(iss_valid), 64'd0);
    chk("t7_rst_occ", 64'(occupancy), 64'd0);
    chk("t7_rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("t7_rst_rob", 64'(iss_rob_id), 64'd0);
    chk("t7_rst_pay", iss_payload[1], 64'd0);
    cyc(); reset_n = 1'b1; iss_ready = '1;
    for (int c = 0; c < 3; c++) begin
      cyc(); #1 chk("t7_no_issue", 64'(iss_valid), 64'd0);
    end

    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ace_issue_queue.md
Name: ace_issue_queue

Overview:
- Parameterised out-of-order issue queue (reservation station) that replaces the fixed-size scheduler between rename/dispatch and register read.
- Accepts up to DISP_W instructions per cycle and tracks source-operand readiness through WAKE_W wakeup tag ports.
- Selects up to ISSUE_W ready entries per cycle, oldest-first via an age matrix, and hands them to register read with a per-port valid/ready handshake.
- Adds generalised depth/width, oldest-first select, issue back-pressure and same-cycle wakeup capture at dispatch.

Parameters:
- ENTRIES, 16, queue depth (power of two, 4..64).
- DISP_W, 4, dispatch slots per cycle.
- ISSUE_W, 2, issue ports per cycle.
- WAKE_W, 6, wakeup tag broadcast ports (4 ALU + 2 MOB hint).
- PREG_W, 7, physical register tag width.
- ROB_W, 6, ROB id width.
- PAY_W, 64, opaque payload width (opcode, imm, dest, flags).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous full flush (mispredict/exception).
- disp_valid  in  DISP_W  per-slot dispatch valid.
- disp_src1_tag  in  DISP_W*PREG_W  source 1 tag per slot.
- disp_src2_tag  in  DISP_W*PREG_W  source 2 tag per slot.
- disp_src_rdy  in  DISP_W*2  ready bits from the ready table; bit 2k = src1, 2k+1 = src2.
- disp_rob_id  in  DISP_W*ROB_W  ROB id per slot.
- disp_payload  in  DISP_W*PAY_W  payload per slot.
- disp_ready  out  1  high when free entries >= DISP_W.
- wake_valid  in  WAKE_W  wakeup broadcast valid.
- wake_tag  in  WAKE_W*PREG_W  wakeup destination tags.
- iss_valid  out  ISSUE_W  issue port valid.
- iss_ready  in  ISSUE_W  downstream accepts.
- iss_src1_tag  out  ISSUE_W*PREG_W  source 1 tag.
- iss_src2_tag  out  ISSUE_W*PREG_W  source 2 tag.
- iss_rob_id  out  ISSUE_W*ROB_W  ROB id.
- iss_payload  out  ISSUE_W*PAY_W  payload.
- occupancy  out  log2(ENTRIES)+1  valid entry count.

Behaviour:
- Reset (async, reset_n low):
  - All entry valid bits, ready bits and the age matrix clear.
  - iss_valid=0, occupancy=0, disp_ready=1; iss_* data outputs are 0.
- Entry state: valid, src1_rdy, src2_rdy, src tags, rob_id, payload. age[i][j]=1 means entry i is older than entry j.
- Dispatch:
  - Accepted on a rising edge only when disp_valid[k] && disp_ready && !flush.
  - Valid slots are allocated to free entries in lowest-free-index order; slot k is always older than slot k+1.
  - disp_valid while disp_ready=0 is a protocol error (assertion); the instruction is dropped and no state changes.
- Age update on allocation of entry e:
  - Row e cleared: a new entry is older than nothing resident.
  - Column e set for all valid entries and for earlier slots allocated in the same cycle.
- Wakeup:
  - Each cycle, any valid entry whose src tag equals a valid wake_tag sets that src ready at the edge.
  - A dispatching slot whose source matches a same-cycle wake_tag is written ready (no lost wakeup).
  - Tag 0 is hardwired ready; it never needs a wakeup.
- Request: req[i] = valid && src1_rdy && src2_rdy, evaluated from registered state only. Minimum dispatch-to-iss_valid latency is 1 cycle; minimum wakeup-to-iss_valid latency is 1 cycle.
- Select:
  - Port 0 takes the entry with req set and no older requester (age-matrix grant).
  - Port p takes the oldest requester excluding entries granted to ports 0..p-1.
  - iss_valid[p]=0 when no candidate remains.
  - Outputs are combinational from entry state (mux by one-hot grant).
- Handshake:
  - An entry is deallocated at the edge when iss_valid[p] && iss_ready[p].
  - If iss_ready[p]=0, the entry stays resident and is re-selected next cycle; it is still the oldest, so the choice is stable.
  - A port whose ready is low never causes another port to skip entries.
- disp_ready: combinational, (ENTRIES - occupancy) >= DISP_W; it does not count same-cycle issue frees.
- occupancy: registered, occupancy + allocs - issues; it cannot overflow because of the disp_ready rule.
- Flush:
  - iss_valid is forced 0 in the flush cycle.
  - At the edge, all valid bits and the age matrix clear; dispatch and issue in that cycle have no effect.
  - occupancy=0 next cycle.
- Simultaneous events:
  - Issue and dispatch of the same entry index in one cycle cannot happen, because an entry is allocated only when free.
  - Wakeup of an entry being issued is harmless.

Decomposition:
- Package ace_iq_pkg: entry struct/field offsets, clog2 function, TAG_ZERO constant.
- Sub-module ace_age_select: ENTRIES-wide req vector plus age matrix in, one-hot oldest grant out. It is instantiated ISSUE_W times in a masked chain.

Test Plan:
- Reset then dispatch 2 instructions with both sources ready (rob 5, 6) -> next cycle iss_valid=2'b11, port0 rob 5, port1 rob 6; occupancy 2 then 0.
- Dispatch rob 3 with src1 tag 12 not ready, then pulse wake_tag=12 two cycles later -> iss_valid[0] rises the cycle after the wakeup; it is never issued earlier.
- Same-cycle capture: dispatch with src tag 20 not ready while wake_tag=20 is valid -> issues 1 cycle later.
- Fill ENTRIES-DISP_W+1 entries -> disp_ready=0. Hold iss_ready=0 for 3 cycles -> the same oldest rob id is held on port 0 and occupancy is unchanged.
- Age: dispatch rob 1..4 not ready, then wake all sources in reverse order in one cycle -> port0 rob 1, port1 rob 2, then rob 3/4 the following cycle.
- Flush with 8 resident entries plus a dispatch in the same cycle -> iss_valid=0 that cycle, occupancy=0 next cycle, and no later issue of the flushed rob ids. Asserting reset_n=0 mid-operation -> outputs reach their reset values immediately.
